// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI command sequencer slice:
//   - default parameter values for data/address widths, FIFO depth, timeout
//     and synchronizer length
//   - sequencer state encoding (gray-ordered around the normal loop)
//   - request record layout helper: {rd_we, address, data}
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int              DEF_DATA_WIDTH     = 32;
    localparam int              DEF_ADDRESS_WIDTH  = 32;
    localparam int              DEF_FIFO_DEPTH     = 4;
    localparam logic [15:0]     DEF_TIMEOUT_CYCLES = 16'hFFFF;
    localparam int              DEF_SYNC_STAGES    = 2;
    localparam int              TIMER_WIDTH        = 16;

    // IDLE -> ISSUE -> WAIT_DONE -> RESP -> IDLE changes one bit per step.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_DONE = 2'b11,
        RESP      = 2'b10
    } seq_state_t;

    // Width of one queued request record {rd_we, address, data}.
    function automatic int req_width(input int address_width, input int data_width);
        return 1 + address_width + data_width;
    endfunction

endpackage

// File: rtl/spi_req_fifo.sv
// ---------------------------------------------------------------------------
// spi_req_fifo
// Synchronous request FIFO with a registered head stage. Entries land in the
// storage array first and are moved into the head register on the following
// edge, so a freshly pushed entry becomes visible (empty=0) one edge after the
// push. level counts storage entries plus a valid head.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   push       in   write push_data (caller guarantees !full)
//   push_data  in   WIDTH-bit record
//   pop        in   consume the head (caller guarantees !empty)
//   head       out  registered head record
//   full       out  level == DEPTH
//   empty      out  no valid head
//   level      out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module spi_req_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] mem_count;
    logic             head_valid;
    logic             load_head;

    // Refill the head whenever it is empty or being consumed this edge.
    assign load_head = (mem_count != '0) && (!head_valid || pop);

    // NOTE: storage is deliberately left out of reset; the pointers and counts
    // define which entries are meaningful, so clearing the array buys nothing.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all flops sample
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load_head) begin
                head       <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
                head_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
            mem_count <= mem_count + LVL_W'(push) - LVL_W'(load_head);
        end
    end

    assign level = mem_count + LVL_W'(head_valid);
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = !head_valid;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// spi_cmd_sequencer
// Front-end for an SPI master. Read/write commands are queued in a small
// FIFO and issued one at a time on the master's enable/address/data/rd_we
// interface. The master's busy and data_read_valid come from its SCK-derived
// domain and are synchronized here. Every accepted command yields exactly one
// response (read data or write ack, plus an error flag), in command order.
//
// Ports:
//   clock, reset                      system clock, sync active-high reset
//   req_valid/req_ready               command handshake (ready = FIFO not full)
//   req_rd_we/req_address/req_data    command: 1=read, 0=write
//   resp_valid/resp_ready             response handshake, held until taken
//   resp_data/resp_rd/resp_error      read data (0 for writes/errors), rd_we
//                                     copy, timeout or missing-read-data flag
//   spi_enable/spi_rd_we/spi_address/spi_data   to master
//   spi_busy/spi_data_read/spi_data_read_valid  from master (async flags)
//   fifo_level                        current request FIFO occupancy
// ---------------------------------------------------------------------------
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int          DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int          ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int          FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rd_we,
    input  logic [ADDRESS_WIDTH-1:0]      req_address,
    input  logic [DATA_WIDTH-1:0]         req_data,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_rd,
    output logic                          resp_error,
    output logic                          spi_enable,
    output logic                          spi_rd_we,
    output logic [ADDRESS_WIDTH-1:0]      spi_address,
    output logic [DATA_WIDTH-1:0]         spi_data,
    input  logic                          spi_busy,
    input  logic [DATA_WIDTH-1:0]         spi_data_read,
    input  logic                          spi_data_read_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int REQ_W = req_width(ADDRESS_WIDTH, DATA_WIDTH);

    seq_state_t              state;
    seq_state_t              state_next;

    logic [REQ_W-1:0]        fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic [SYNC_STAGES-1:0]  busy_sync;
    logic [SYNC_STAGES-1:0]  vld_sync;
    logic                    busy_s;
    logic                    vld_s;
    logic                    vld_s_d;
    logic                    vld_rise;

    logic [TIMER_WIDTH-1:0]  timer;
    logic                    timer_done;
    logic                    rd_captured;

    logic                    load_cmd;
    logic                    capture;
    logic                    set_error;

    // ---------------------------------------------------------------------
    // Request FIFO
    // ---------------------------------------------------------------------
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;

    spi_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({req_rd_we, req_address, req_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // ---------------------------------------------------------------------
    // Synchronizers for the master's SCK-domain status flags
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_sync <= '0;
            vld_sync  <= '0;
            vld_s_d   <= 1'b0;
        end else begin
            busy_sync <= {busy_sync[SYNC_STAGES-2:0], spi_busy};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], spi_data_read_valid};
            vld_s_d   <= vld_s;
        end
    end

    assign busy_s   = busy_sync[SYNC_STAGES-1];
    assign vld_s    = vld_sync[SYNC_STAGES-1];
    assign vld_rise = vld_s && !vld_s_d;

    assign timer_done = (timer == TIMEOUT_CYCLES);

    // ---------------------------------------------------------------------
    // Sequencer FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer FSM: next state and control strobes
    // ---------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        load_cmd   = 1'b0;
        capture    = 1'b0;
        set_error  = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_cmd   = 1'b1;
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                if (busy_s) begin
                    state_next = WAIT_DONE;
                end else if (timer_done) begin
                    set_error  = 1'b1;
                    state_next = RESP;
                end
            end

            WAIT_DONE: begin
                if (vld_rise && spi_rd_we) begin
                    capture = 1'b1;
                end
                if (!busy_s) begin
                    // A capture on this same cycle still counts as read data.
                    set_error  = spi_rd_we && !rd_captured && !capture;
                    state_next = RESP;
                end else if (timer_done) begin
                    set_error  = 1'b1;
                    state_next = RESP;
                end
            end

            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: master-side command registers, response registers, timer
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            spi_enable  <= 1'b0;
            spi_rd_we   <= 1'b0;
            spi_address <= '0;
            spi_data    <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_rd     <= 1'b0;
            resp_error  <= 1'b0;
            rd_captured <= 1'b0;
            timer       <= '0;
        end else begin
            // Registered decode of the next state keeps these outputs glitch-free.
            spi_enable <= (state_next == ISSUE);
            resp_valid <= (state_next == RESP);

            // Cleared on every state entry, otherwise counts up and saturates.
            if (state_next != state) begin
                timer <= '0;
            end else if (!timer_done) begin
                timer <= timer + 1'b1;
            end

            if (load_cmd) begin
                {spi_rd_we, spi_address, spi_data} <= fifo_head;
                rd_captured <= 1'b0;
                resp_data   <= '0;
                resp_error  <= 1'b0;
            end

            if (capture) begin
                resp_data   <= spi_data_read;
                rd_captured <= 1'b1;
            end

            // Errors always report zero data, overriding any capture.
            if (set_error) begin
                resp_error <= 1'b1;
                resp_data  <= '0;
            end

            if ((state_next == RESP) && (state != RESP)) begin
                resp_rd <= spi_rd_we;
            end
        end
    end

endmodule
